// File: rtl/aes_pkg.sv
// Shared AES MixColumns types and GF(2^8) helpers, reduction polynomial 0x11b.
// All multiples are built from xtime and XOR so no multiplier is ever inferred.
package aes_pkg;

    typedef logic [7:0]    byte_t;
    typedef logic [31:0]   column_t;
    // Column 0 sits in the most significant 32 bits, matching the bus layout.
    typedef column_t [0:3] state_t;

    typedef enum logic {
        MC_FWD = 1'b0,
        MC_INV = 1'b1
    } mc_mode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul2(input byte_t b);
        return xtime(b);
    endfunction

    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

    function automatic byte_t gf_mul9(input byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic byte_t gf_mulb(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic byte_t gf_muld(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic byte_t gf_mule(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// The row-0 byte is the most significant byte of the column.
import aes_pkg::*;

module mix_column_word (
    input  column_t  col_i,
    input  mc_mode_e mode_i,
    output column_t  col_o
);

    byte_t a, b, c, d;

    assign {a, b, c, d} = col_i;

    always_comb begin
        if (mode_i == MC_FWD) begin
            col_o = {gf_mul2(a) ^ gf_mul3(b) ^ c ^ d,
                     a ^ gf_mul2(b) ^ gf_mul3(c) ^ d,
                     a ^ b ^ gf_mul2(c) ^ gf_mul3(d),
                     gf_mul3(a) ^ b ^ c ^ gf_mul2(d)};
        end else begin
            col_o = {gf_mule(a) ^ gf_mulb(b) ^ gf_muld(c) ^ gf_mul9(d),
                     gf_mul9(a) ^ gf_mule(b) ^ gf_mulb(c) ^ gf_muld(d),
                     gf_muld(a) ^ gf_mul9(b) ^ gf_mule(c) ^ gf_mulb(d),
                     gf_mulb(a) ^ gf_muld(b) ^ gf_mul9(c) ^ gf_mule(d)};
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Handshaked AES MixColumns/InvMixColumns engine; COLS_PER_CYCLE columns per beat,
// transformed in place in the state register over 4/COLS_PER_CYCLE beats.
import aes_pkg::*;

module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         MODE,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA
);

    localparam int NBEATS = 4 / COLS_PER_CYCLE;
    localparam int SHIFT  = (COLS_PER_CYCLE == 1) ? 0 : ((COLS_PER_CYCLE == 2) ? 1 : 2);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0] fsm_q, fsm_d;
    logic [1:0] beat_q, beat_d;
    state_t     state_q, state_d, state_xf;
    mc_mode_e   mode_q, mode_d;
    logic       accept;
    logic       last_beat;

    column_t    mixed   [COLS_PER_CYCLE];
    logic [1:0] col_idx [COLS_PER_CYCLE];

    assign IN_READY  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign last_beat = (beat_q == 2'(NBEATS - 1));
    assign OUT_VALID = (fsm_q == ST_DONE);
    assign OUT_DATA  = state_q;

    // Beat b owns the contiguous column group starting at b*COLS_PER_CYCLE.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_idx[k] = (beat_q << SHIFT) | 2'(k);

        mix_column_word u_mcw (
            .col_i  (state_q[col_idx[k]]),
            .mode_i (mode_q),
            .col_o  (mixed[k])
        );
    end

    always_comb begin
        state_xf = state_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            state_xf[col_idx[k]] = mixed[k];
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        beat_d  = beat_q;
        state_d = state_q;
        mode_d  = mode_q;
        case (fsm_q)
            ST_IDLE: ;
            ST_BUSY: begin
                state_d = state_xf;
                beat_d  = beat_q + 2'd1;
                if (last_beat) begin
                    fsm_d  = ST_DONE;
                    beat_d = 2'd0;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        // A new block may be taken from IDLE or on the same edge the result leaves DONE.
        if (accept) begin
            state_d = IN_DATA;
            mode_d  = mc_mode_e'(MODE);
            beat_d  = 2'd0;
            fsm_d   = ST_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            beat_q  <= 2'd0;
            state_q <= '0;
            mode_q  <= MC_FWD;
        end else begin
            fsm_q   <= fsm_d;
            beat_q  <= beat_d;
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine at COLS_PER_CYCLE = 1, 2 and 4 side by side.
module tb_mix_columns_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    localparam logic [127:0] V_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V_C6  = 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] V_C6O = 128'hc6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply, independent of any xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] p, a, b;
        logic       hi;
        p = 8'h00; a = a_in; b = b_in;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   col  [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) col[j] = s[127 - 32*c - 8*j -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(col[j], base[(j - r + 4) % 4]);
                o[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int P  = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        localparam int NB = 4 / P;

        logic         rst_n, in_valid, in_ready, mode, out_valid, out_ready;
        logic [127:0] in_data, out_data;
        exp_t         exp_q [$];
        bit           done = 1'b0;
        logic         prev_valid = 1'b0;

        mix_columns_engine #(.COLS_PER_CYCLE(P)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .IN_VALID  (in_valid),
            .IN_READY  (in_ready),
            .IN_DATA   (in_data),
            .MODE      (mode),
            .OUT_VALID (out_valid),
            .OUT_READY (out_ready),
            .OUT_DATA  (out_data)
        );

        // Monitor: checks every presented result against the scoreboard front.
        always @(negedge clk) begin
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL P%0d unexpected_output: got %h required no output", P, out_data);
                end else begin
                    if (!prev_valid)
                        chk($sformatf("P%0d latency", P), 128'(cyc), 128'(exp_q[0].acc + 1 + NB));
                    chk($sformatf("P%0d out_data", P), out_data, exp_q[0].data);
                    chk($sformatf("P%0d in_ready_done", P), 128'(in_ready), 128'(out_ready));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end

        // Called at a negedge; returns just after the accepting edge with
        // acc = cycle count seen before that edge, or -1 on timeout.
        task automatic send(input logic [127:0] d, input logic m, input logic [127:0] e, output int acc);
            exp_t item;
            in_valid = 1'b1;
            in_data  = d;
            mode     = m;
            acc      = -1;
            for (int t = 0; t < 64; t++) begin
                #1;
                if (in_ready) begin
                    acc       = cyc;
                    item.data = e;
                    item.acc  = cyc;
                    exp_q.push_back(item);
                    break;
                end
                @(negedge clk);
            end
            if (acc < 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL P%0d accept_timeout: got no IN_READY required IN_READY within 64 cycles", P);
                in_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                // Garbage on data and MODE while the block is in flight.
                in_valid = 1'b0;
                mode     = ~m;
                in_data  = ~d;
            end
        endtask

        initial begin
            int           a, b, prev;
            logic [127:0] x, e;
            logic         m;
            rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b1;
            repeat (2) @(negedge clk);
            chk($sformatf("P%0d rst_out_valid", P), 128'(out_valid), 128'd0);
            chk($sformatf("P%0d rst_out_data", P), out_data, 128'd0);
            rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("P%0d rst_in_ready", P), 128'(in_ready), 128'd1);

            @(negedge clk); send(V_IN,  1'b0, V_OUT, a);
            @(negedge clk); send(V_OUT, 1'b1, V_IN,  a);
            @(negedge clk); send(V_C6,  1'b0, V_C6O, a);
            repeat (NB + 2) @(negedge clk);

            // Backpressure, then a new block taken on the releasing edge.
            out_ready = 1'b0;
            @(negedge clk); send(V_IN, 1'b0, V_OUT, a);
            repeat (NB + 5) @(negedge clk);
            out_ready = 1'b1;
            send(V_C6, 1'b0, V_C6O, b);
            chk($sformatf("P%0d bp_same_edge_accept", P), 128'(b), 128'(a + NB + 5));
            repeat (NB + 2) @(negedge clk);

            // Back-to-back with alternating mode.
            prev = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (i % 2 == 0) send(V_IN,  1'b0, V_OUT, a);
                else            send(V_OUT, 1'b1, V_IN,  a);
                if (i > 0) chk($sformatf("P%0d throughput", P), 128'(a - prev), 128'(NB + 1));
                prev = a;
            end
            repeat (NB + 2) @(negedge clk);

            // Reset while BUSY discards the block.
            @(negedge clk); send(V_IN, 1'b0, V_OUT, a);
            repeat (NB - 1) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            exp_q.delete();
            #1;
            chk($sformatf("P%0d midrst_out_valid", P), 128'(out_valid), 128'd0);
            chk($sformatf("P%0d midrst_out_data", P), out_data, 128'd0);
            chk($sformatf("P%0d midrst_in_ready", P), 128'(in_ready), 128'd1);
            rst_n = 1'b1;
            @(negedge clk); send(V_IN, 1'b0, V_OUT, a);
            repeat (NB + 2) @(negedge clk);

            // Random states with a round trip through the opposite mode.
            for (int i = 0; i < 1500; i++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                m = 1'($urandom_range(0, 1));
                e = ref_mc(x, m);
                @(negedge clk); send(x, m, e, a);
                @(negedge clk); send(e, ~m, x, a);
            end
            repeat (NB + 3) @(negedge clk);
            chk($sformatf("P%0d scoreboard_drained", P), 128'(exp_q.size()), 128'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 90000; t++) begin
            @(posedge clk);
            if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got unfinished stimulus required completion within 90000 cycles");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
